mipi_tx_video_gen: RTL and testbench

//  Video timing and test-pattern source feeding the MIPI CSI-2 TX hard block. Generates

---
 rtl/mipi_tx_video_gen.sv | 169 ++++++++++++++++
 tb/tb_mipi_tx_video_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_tx_video_gen.sv
// Video timing and test-pattern source for the MIPI CSI-2 TX hard block.
// Emits VSYNC/HSYNC/VALID framing and two RGB888 pixels per clock.
module mipi_tx_video_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 40,
    parameter int H_FP     = 40,
    parameter int V_ACTIVE = 1080,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 4,
    parameter int V_FP     = 4
) (
    input  logic        tx_pixel_clk,
    input  logic        rst,
    input  logic        stream_en,
    input  logic        pat_sel,
    output logic        tx_vsync,
    output logic        tx_hsync,
    output logic        tx_valid,
    output logic [63:0] tx_data,
    output logic [15:0] tx_hres,
    output logic [5:0]  tx_type,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam logic [15:0] H_LAST   = 16'(H_SYNC + H_BP + H_ACTIVE / 2 + H_FP - 1);
    localparam logic [15:0] V_LAST   = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [15:0] HS_END   = 16'(H_SYNC);
    localparam logic [15:0] HA_START = 16'(H_SYNC + H_BP);
    localparam logic [15:0] HA_END   = 16'(H_SYNC + H_BP + H_ACTIVE / 2);
    localparam logic [15:0] VS_END   = 16'(V_SYNC);
    localparam logic [15:0] VA_START = 16'(V_SYNC + V_BP);
    localparam logic [15:0] VA_END   = 16'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [1:0]  en_sync, pat_sync;
    logic        en_s, pat_s;
    logic [15:0] hcnt, vcnt, hcnt_n, vcnt_n, fc_n;
    logic        pat_q, pat_n;
    logic [7:0]  fc_lat, fcl_n;
    logic        run_n, vsync_n, hsync_n, valid_n;
    logic [15:0] x;
    logic [7:0]  y8;
    logic [23:0] px0, px1;
    logic [63:0] data_n;

    assign en_s    = en_sync[1];
    assign pat_s   = pat_sync[1];
    assign tx_hres = 16'(H_ACTIVE);
    assign tx_type = 6'h24;

    function automatic logic [2:0] bar_index(input logic [15:0] px);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (px >= 16'(i * (H_ACTIVE / 8))) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Next counter/FSM state; outputs are registered from these so the
    // FSM transition and the first framing beat land on the same edge.
    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        vcnt_n  = vcnt;
        fc_n    = frame_cnt;
        pat_n   = pat_q;
        fcl_n   = fc_lat;
        case (state)
            IDLE: begin
                if (en_s) begin
                    state_n = RUN;
                    hcnt_n  = '0;
                    vcnt_n  = '0;
                    pat_n   = pat_s;
                    fcl_n   = frame_cnt[7:0];
                end
            end
            RUN: begin
                if (hcnt == H_LAST) begin
                    hcnt_n = '0;
                    if (vcnt == V_LAST) begin
                        fc_n   = frame_cnt + 16'd1;
                        vcnt_n = '0;
                        if (en_s) begin
                            pat_n = pat_s;
                            fcl_n = fc_n[7:0];
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        vcnt_n = vcnt + 16'd1;
                    end
                end else begin
                    hcnt_n = hcnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        run_n   = (state_n == RUN);
        vsync_n = run_n && (vcnt_n < VS_END);
        hsync_n = run_n && (hcnt_n < HS_END);
        valid_n = run_n && (hcnt_n >= HA_START) && (hcnt_n < HA_END)
                        && (vcnt_n >= VA_START) && (vcnt_n < VA_END);
        x  = (hcnt_n - HA_START) << 1;
        y8 = vcnt_n[7:0] - VA_START[7:0];
        if (!pat_n) begin
            px0 = bar_colour(bar_index(x));
            px1 = px0;
        end else begin
            px0 = {x[7:0], y8, fcl_n};
            px1 = {x[7:1], 1'b1, y8, fcl_n};
        end
        data_n = valid_n ? {16'h0000, px1, px0} : 64'h0;
    end

    always_ff @(posedge tx_pixel_clk) begin
        if (rst) begin
            en_sync   <= '0;
            pat_sync  <= '0;
            state     <= IDLE;
            hcnt      <= '0;
            vcnt      <= '0;
            frame_cnt <= '0;
            pat_q     <= 1'b0;
            fc_lat    <= '0;
            tx_vsync  <= 1'b0;
            tx_hsync  <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
        end else begin
            en_sync   <= {en_sync[0], stream_en};
            pat_sync  <= {pat_sync[0], pat_sel};
            state     <= state_n;
            hcnt      <= hcnt_n;
            vcnt      <= vcnt_n;
            frame_cnt <= fc_n;
            pat_q     <= pat_n;
            fc_lat    <= fcl_n;
            tx_vsync  <= vsync_n;
            tx_hsync  <= hsync_n;
            tx_valid  <= valid_n;
            tx_data   <= data_n;
            busy      <= run_n;
        end
    end

endmodule

// File: tb/tb_mipi_tx_video_gen.sv
// Directed bench for mipi_tx_video_gen with small timing (L = 14, F = 7).
module tb_mipi_tx_video_gen;

    localparam int L = 14;
    localparam int F = 7;
    localparam int N = L * F;

    logic        clk;
    logic        rst;
    logic        stream_en;
    logic        pat_sel;
    logic        tx_vsync, tx_hsync, tx_valid, busy;
    logic [63:0] tx_data;
    logic [15:0] tx_hres, frame_cnt;
    logic [5:0]  tx_type;

    int n_cmp = 0;
    int n_err = 0;

    logic        cap_vs[N];
    logic        cap_hs[N];
    logic        cap_vld[N];
    logic        cap_busy[N];
    logic [63:0] cap_data[N];
    logic [15:0] cap_fc[N];

    logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    mipi_tx_video_gen #(
        .H_ACTIVE(16), .H_SYNC(2), .H_BP(2), .H_FP(2),
        .V_ACTIVE(4), .V_SYNC(1), .V_BP(1), .V_FP(1)
    ) dut (
        .tx_pixel_clk(clk),
        .rst(rst),
        .stream_en(stream_en),
        .pat_sel(pat_sel),
        .tx_vsync(tx_vsync),
        .tx_hsync(tx_hsync),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_hres(tx_hres),
        .tx_type(tx_type),
        .frame_cnt(frame_cnt),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic sample(input int i);
        cap_vs[i]   = tx_vsync;
        cap_hs[i]   = tx_hsync;
        cap_vld[i]  = tx_valid;
        cap_busy[i] = busy;
        cap_data[i] = tx_data;
        cap_fc[i]   = frame_cnt;
    endtask

    task automatic capture_frame(input int start, input int pat_at, input logic pat_val, input int en_at);
        for (int i = start; i < N; i++) begin
            @(posedge clk);
            @(negedge clk);
            sample(i);
            if (i == pat_at) pat_sel = pat_val;
            if (i == en_at) stream_en = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        stream_en = 1'b0;
        pat_sel = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (tx_vsync !== 1'b0) begin n_err++; $display("FAIL reset_vsync: got %0b want 0", tx_vsync); end
        n_cmp++; if (tx_hsync !== 1'b0) begin n_err++; $display("FAIL reset_hsync: got %0b want 0", tx_hsync); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", tx_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (frame_cnt !== 16'h0) begin n_err++; $display("FAIL reset_frame_cnt: got %0h want 0", frame_cnt); end
        n_cmp++; if (tx_hres !== 16'd16) begin n_err++; $display("FAIL reset_hres: got %0d want 16", tx_hres); end
        n_cmp++; if (tx_type !== 6'h24) begin n_err++; $display("FAIL reset_type: got %0h want 24", tx_type); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({busy, tx_vsync, tx_hsync} !== 3'b000) begin n_err++; $display("FAIL idle_outputs: got %b want 000", {busy, tx_vsync, tx_hsync}); end
    endtask

    task automatic test_startup;
        int n;
        bit found;
        int vs_tot, vld_tot, line, col;
        logic e_vs, e_hs, e_vld;
        n = 0;
        found = 0;
        stream_en = 1'b1;
        while (!found && n < 10) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (tx_vsync) found = 1;
        end
        n_cmp++; if (n !== 3) begin n_err++; $display("FAIL start_latency: got %0d clocks want 3", n); end
        sample(0);
        // pat_sel flips mid-frame; this frame must stay colour bars
        capture_frame(1, 30, 1'b1, -1);
        vs_tot = 0;
        vld_tot = 0;
        for (int i = 0; i < N; i++) begin
            line  = i / L;
            col   = i % L;
            e_vs  = (line < 1);
            e_hs  = (col < 2);
            e_vld = (line >= 2) && (line < 6) && (col >= 4) && (col < 12);
            vs_tot  += int'(cap_vs[i]);
            vld_tot += int'(cap_vld[i]);
            n_cmp++; if (cap_vs[i] !== e_vs) begin n_err++; $display("FAIL vsync[%0d]: got %0b want %0b", i, cap_vs[i], e_vs); end
            n_cmp++; if (cap_hs[i] !== e_hs) begin n_err++; $display("FAIL hsync[%0d]: got %0b want %0b", i, cap_hs[i], e_hs); end
            n_cmp++; if (cap_vld[i] !== e_vld) begin n_err++; $display("FAIL valid[%0d]: got %0b want %0b", i, cap_vld[i], e_vld); end
            n_cmp++; if (cap_busy[i] !== 1'b1) begin n_err++; $display("FAIL busy[%0d]: got %0b want 1", i, cap_busy[i]); end
        end
        n_cmp++; if (vs_tot !== 14) begin n_err++; $display("FAIL vsync_len: got %0d want 14", vs_tot); end
        n_cmp++; if (vld_tot !== 32) begin n_err++; $display("FAIL valid_beats: got %0d want 32", vld_tot); end
    endtask

    task automatic test_colour_bars;
        int k;
        logic [63:0] exp;
        n_cmp++; if (cap_fc[0] !== 16'd0) begin n_err++; $display("FAIL bars_fc: got %0d want 0", cap_fc[0]); end
        n_cmp++; if (cap_data[32] !== 64'h0000_FFFFFF_FFFFFF) begin n_err++; $display("FAIL bars_beat0: got %h want 0000ffffffffffff", cap_data[32]); end
        n_cmp++; if (cap_data[33] !== 64'h0000_FFFF00_FFFF00) begin n_err++; $display("FAIL bars_beat1: got %h want 0000ffff00ffff00", cap_data[33]); end
        n_cmp++; if (cap_data[34] !== 64'h0000_00FFFF_00FFFF) begin n_err++; $display("FAIL bars_beat2: got %h want 000000ffff00ffff", cap_data[34]); end
        n_cmp++; if (cap_data[39] !== 64'h0) begin n_err++; $display("FAIL bars_beat7: got %h want 0", cap_data[39]); end
        for (int i = 0; i < N; i++) begin
            if (cap_vld[i]) begin
                k = (i % L) - 4;
                exp = {16'h0000, bars[k], bars[k]};
            end else begin
                exp = 64'h0;
            end
            n_cmp++; if (cap_data[i] !== exp) begin n_err++; $display("FAIL bars_data[%0d]: got %h want %h", i, cap_data[i], exp); end
        end
    endtask

    task automatic test_pattern_switch;
        int k, y;
        logic [63:0] exp;
        capture_frame(0, -1, 1'b1, -1);
        n_cmp++; if (cap_fc[0] !== 16'd1) begin n_err++; $display("FAIL switch_fc: got %0d want 1", cap_fc[0]); end
        n_cmp++; if (cap_vs[0] !== 1'b1) begin n_err++; $display("FAIL switch_vsync: got %0b want 1", cap_vs[0]); end
        for (int i = 0; i < N; i++) begin
            if (cap_vld[i]) begin
                k = (i % L) - 4;
                y = (i / L) - 2;
                exp = {16'h0000, 8'(2 * k + 1), 8'(y), 8'h01, 8'(2 * k), 8'(y), 8'h01};
            end else begin
                exp = 64'h0;
            end
            n_cmp++; if (cap_data[i] !== exp) begin n_err++; $display("FAIL grad1_data[%0d]: got %h want %h", i, cap_data[i], exp); end
        end
    endtask

    task automatic test_gradient;
        int k, y;
        logic [63:0] exp;
        capture_frame(0, -1, 1'b1, -1);
        n_cmp++; if (cap_fc[0] !== 16'd2) begin n_err++; $display("FAIL grad_fc2: got %0d want 2", cap_fc[0]); end
        // last frame: stream_en drops 20 clocks in
        capture_frame(0, -1, 1'b1, 20);
        n_cmp++; if (cap_fc[0] !== 16'd3) begin n_err++; $display("FAIL grad_fc3: got %0d want 3", cap_fc[0]); end
        n_cmp++; if (cap_data[48] !== 64'h0000_050103_040103) begin n_err++; $display("FAIL grad_y1_beat2: got %h want 0000050103040103", cap_data[48]); end
        for (int i = 0; i < N; i++) begin
            if (cap_vld[i]) begin
                k = (i % L) - 4;
                y = (i / L) - 2;
                exp = {16'h0000, 8'(2 * k + 1), 8'(y), 8'h03, 8'(2 * k), 8'(y), 8'h03};
            end else begin
                exp = 64'h0;
            end
            n_cmp++; if (cap_data[i] !== exp) begin n_err++; $display("FAIL grad3_data[%0d]: got %h want %h", i, cap_data[i], exp); end
        end
    endtask

    task automatic test_stop;
        int busy_tot, late;
        busy_tot = 0;
        late = 0;
        for (int i = 0; i < N; i++) busy_tot += int'(cap_busy[i]);
        n_cmp++; if (busy_tot !== N) begin n_err++; $display("FAIL stop_busy_frame: got %0d want %0d", busy_tot, N); end
        n_cmp++; if (cap_vld[75] !== 1'b1) begin n_err++; $display("FAIL stop_last_line_valid: got %0b want 1", cap_vld[75]); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %0b want 0", busy); end
        n_cmp++; if (frame_cnt !== 16'd4) begin n_err++; $display("FAIL stop_frame_cnt: got %0d want 4", frame_cnt); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (tx_vsync || busy || tx_hsync) late++;
        end
        n_cmp++; if (late !== 0) begin n_err++; $display("FAIL stop_quiet: got %0d active clocks want 0", late); end
    endtask

    task automatic test_mid_reset;
        int n;
        stream_en = 1'b1;
        n = 0;
        while (!tx_valid && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!tx_valid) begin
            n_err++;
            $display("FAIL midrst_wait: got no valid in 200 clocks want valid");
        end else begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if ({tx_valid, tx_hsync, tx_vsync, busy} !== 4'b0000) begin n_err++; $display("FAIL midrst_framing: got %b want 0000", {tx_valid, tx_hsync, tx_vsync, busy}); end
            n_cmp++; if (tx_data !== 64'h0) begin n_err++; $display("FAIL midrst_data: got %h want 0", tx_data); end
            n_cmp++; if (frame_cnt !== 16'h0) begin n_err++; $display("FAIL midrst_frame_cnt: got %0d want 0", frame_cnt); end
            n_cmp++; if (tx_hres !== 16'd16) begin n_err++; $display("FAIL midrst_hres: got %0d want 16", tx_hres); end
            n_cmp++; if (tx_type !== 6'h24) begin n_err++; $display("FAIL midrst_type: got %0h want 24", tx_type); end
            stream_en = 1'b0;
            rst = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_colour_bars();
        test_pattern_switch();
        test_gradient();
        test_stop();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
